sd_data_control: RTL and testbench
==================================

Name: sd_data_control

Overview:
Control FSM of the SD host data path. It accepts a transfer request from the register/CPU side and latches the transfer configuration. It then sequences block-by-block transfers with the data physical layer (send/ack/complete handshake), gated on FIFO readiness. At the end it reports completion.

Parameters:
BLOCKS_WIDTH, 8, width of block-count field
TIMEOUT_WIDTH, 16, width of timeout register

Ports:
iClock  in  1  system clock, rising edge
iReset  in  1  asynchronous reset, active-low
iWriteRead  in  1  transfer direction, 1=write to card, 0=read
iBlocks  in  BLOCKS_WIDTH  number of blocks requested
iMultipleData  in  1  1=multi-block transfer, 0=single block
iTimeout_enable  in  1  enables timeout value forwarding
iTimeout_reg  in  TIMEOUT_WIDTH  timeout value
iNewData  in  1  start request (level, sampled in IDLE)
iSerial_ready  in  1  physical layer ready to accept configuration
iTimeout  in  1  physical layer timeout event
iComplete  in  1  physical layer finished current block
iAck  in  1  physical layer acknowledge of oAck
iFIFO_ok  in  1  FIFO has data/space for one block
oData_transfer_complete  out  1  one-cycle pulse at end of transfer
oSend  out  1  request physical layer to transfer one block
oAck  out  1  block-done acknowledge toward physical layer
oBlocks  out  BLOCKS_WIDTH  latched block count
oTimeout_val  out  TIMEOUT_WIDTH  latched timeout (0 if disabled)
oWriteRead  out  1  latched direction
oMultipleData  out  1  latched multi-block flag
oIdle  out  1  high while in IDLE

Behaviour:
- Registered Moore outputs. Async reset (iReset=0) -> state IDLE, block counter=0, all outputs 0 except oIdle=1.
- States: IDLE, SETTING, CHECK_FIFO, TRANSMIT, ACK, DONE.
- IDLE: oIdle=1. If iNewData=1, latch config and go to SETTING. Latched config: oWriteRead<=iWriteRead, oMultipleData<=iMultipleData, oBlocks<=iBlocks, oTimeout_val<=iTimeout_enable?iTimeout_reg:0, counter<=0.
- Latched config holds until the next accepted request; inputs changing mid-transfer are ignored.
- Target block count: 1 if iMultipleData=0 or iBlocks=0; otherwise iBlocks.
- SETTING: wait for iSerial_ready=1, then go to CHECK_FIFO.
- CHECK_FIFO: if iTimeout=1, go to DONE (abort). Else if iFIFO_ok=1, go to TRANSMIT. Else stay.
- TRANSMIT: oSend=1. If iTimeout=1, go to DONE (abort; timeout has priority over iComplete in the same cycle). Else if iComplete=1, go to ACK. oSend drops on leaving.
- ACK: oAck=1 until iAck=1. On iAck: counter+1; if counter+1 < target go to CHECK_FIFO, else go to DONE.
- DONE: oData_transfer_complete=1 for exactly one cycle, then go to IDLE.
- oIdle=0 in every state except IDLE. oSend and oAck are never asserted together.
- Counter is BLOCKS_WIDTH wide, no wrap (max 255 blocks).
- Reset asserted mid-transfer -> immediate IDLE, all handshake outputs cleared.

Test Plan:
- Reset: iReset=0 -> oIdle=1, oSend=0, oAck=0, oBlocks=0, oTimeout_val=0, oData_transfer_complete=0.
- Single block: iNewData=1, iMultipleData=0, iBlocks=5, iSerial_ready=1, iFIFO_ok=1, iComplete then iAck -> exactly one oSend pulse-window, one oAck, then a 1-cycle oData_transfer_complete, then oIdle=1.
- Multi-block: iMultipleData=1, iBlocks=3 -> three TRANSMIT/ACK rounds, completion pulse after the third iAck.
- FIFO stall: iFIFO_ok=0 for 10 cycles in CHECK_FIFO -> oSend stays 0; oSend=1 on the cycle after iFIFO_ok=1.
- Timeout: iTimeout_enable=1, iTimeout_reg=16'h1234 -> oTimeout_val=16'h1234. iTimeout=1 during TRANSMIT -> DONE pulse, no oAck. Same request with enable=0 -> oTimeout_val=0.
- Async reset during ACK -> outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/sd_data_control.sv
// SD host data-path control FSM: latches a transfer request, then sequences
// block transfers with the data PHY (send/complete/ack) gated on FIFO readiness.
module sd_data_control #(
    parameter int BLOCKS_WIDTH  = 8,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                     iClock,
    input  logic                     iReset,
    input  logic                     iWriteRead,
    input  logic [BLOCKS_WIDTH-1:0]  iBlocks,
    input  logic                     iMultipleData,
    input  logic                     iTimeout_enable,
    input  logic [TIMEOUT_WIDTH-1:0] iTimeout_reg,
    input  logic                     iNewData,
    input  logic                     iSerial_ready,
    input  logic                     iTimeout,
    input  logic                     iComplete,
    input  logic                     iAck,
    input  logic                     iFIFO_ok,
    output logic                     oData_transfer_complete,
    output logic                     oSend,
    output logic                     oAck,
    output logic [BLOCKS_WIDTH-1:0]  oBlocks,
    output logic [TIMEOUT_WIDTH-1:0] oTimeout_val,
    output logic                     oWriteRead,
    output logic                     oMultipleData,
    output logic                     oIdle
);

    typedef enum logic [2:0] {
        IDLE,
        SETTING,
        CHECK_FIFO,
        TRANSMIT,
        ACK,
        DONE
    } state_t;

    state_t                  state;
    logic [BLOCKS_WIDTH-1:0] block_cnt;
    logic [BLOCKS_WIDTH-1:0] target;
    logic [BLOCKS_WIDTH:0]   cnt_next;

    // One extra bit so the final increment at 255 blocks cannot wrap the compare.
    assign cnt_next = {1'b0, block_cnt} + {{BLOCKS_WIDTH{1'b0}}, 1'b1};

    // Outputs are assigned alongside each transition so they track the next state.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state                   <= IDLE;
            block_cnt               <= '0;
            target                  <= '0;
            oData_transfer_complete <= 1'b0;
            oSend                   <= 1'b0;
            oAck                    <= 1'b0;
            oBlocks                 <= '0;
            oTimeout_val            <= '0;
            oWriteRead              <= 1'b0;
            oMultipleData           <= 1'b0;
            oIdle                   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (iNewData) begin
                        oWriteRead    <= iWriteRead;
                        oMultipleData <= iMultipleData;
                        oBlocks       <= iBlocks;
                        oTimeout_val  <= iTimeout_enable ? iTimeout_reg : '0;
                        target        <= (iMultipleData && iBlocks != '0) ? iBlocks
                                                                          : BLOCKS_WIDTH'(1);
                        block_cnt     <= '0;
                        oIdle         <= 1'b0;
                        state         <= SETTING;
                    end
                end
                SETTING: begin
                    if (iSerial_ready) state <= CHECK_FIFO;
                end
                CHECK_FIFO: begin
                    if (iTimeout) begin
                        oData_transfer_complete <= 1'b1;
                        state                   <= DONE;
                    end else if (iFIFO_ok) begin
                        oSend <= 1'b1;
                        state <= TRANSMIT;
                    end
                end
                TRANSMIT: begin
                    if (iTimeout) begin
                        oSend                   <= 1'b0;
                        oData_transfer_complete <= 1'b1;
                        state                   <= DONE;
                    end else if (iComplete) begin
                        oSend <= 1'b0;
                        oAck  <= 1'b1;
                        state <= ACK;
                    end
                end
                ACK: begin
                    if (iAck) begin
                        oAck      <= 1'b0;
                        block_cnt <= cnt_next[BLOCKS_WIDTH-1:0];
                        if (cnt_next < {1'b0, target}) begin
                            state <= CHECK_FIFO;
                        end else begin
                            oData_transfer_complete <= 1'b1;
                            state                   <= DONE;
                        end
                    end
                end
                DONE: begin
                    oData_transfer_complete <= 1'b0;
                    oIdle                   <= 1'b1;
                    state                   <= IDLE;
                end
                default: begin
                    oData_transfer_complete <= 1'b0;
                    oSend                   <= 1'b0;
                    oAck                    <= 1'b0;
                    oIdle                   <= 1'b1;
                    state                   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_data_control.sv
// Self-checking bench for sd_data_control: a reactive PHY/FIFO emulation drives
// transfers while per-transfer expectations come from the block-count rules.
module tb_sd_data_control;

    logic        iClock;
    logic        iReset;
    logic        iWriteRead;
    logic [7:0]  iBlocks;
    logic        iMultipleData;
    logic        iTimeout_enable;
    logic [15:0] iTimeout_reg;
    logic        iNewData;
    logic        iSerial_ready;
    logic        iTimeout;
    logic        iComplete;
    logic        iAck;
    logic        iFIFO_ok;
    logic        oData_transfer_complete;
    logic        oSend;
    logic        oAck;
    logic [7:0]  oBlocks;
    logic [15:0] oTimeout_val;
    logic        oWriteRead;
    logic        oMultipleData;
    logic        oIdle;

    int total = 0;
    int bad   = 0;

    // Observations of the most recent transfer
    int          obs_sends, obs_acks, obs_pulse, obs_overlap, obs_lat;
    logic        obs_idle_after, obs_hung;
    logic [7:0]  obs_blocks;
    logic [15:0] obs_tval;
    logic        obs_wr, obs_multi;

    sd_data_control #(.BLOCKS_WIDTH(8), .TIMEOUT_WIDTH(16)) dut (
        .iClock(iClock), .iReset(iReset), .iWriteRead(iWriteRead), .iBlocks(iBlocks),
        .iMultipleData(iMultipleData), .iTimeout_enable(iTimeout_enable),
        .iTimeout_reg(iTimeout_reg), .iNewData(iNewData), .iSerial_ready(iSerial_ready),
        .iTimeout(iTimeout), .iComplete(iComplete), .iAck(iAck), .iFIFO_ok(iFIFO_ok),
        .oData_transfer_complete(oData_transfer_complete), .oSend(oSend), .oAck(oAck),
        .oBlocks(oBlocks), .oTimeout_val(oTimeout_val), .oWriteRead(oWriteRead),
        .oMultipleData(oMultipleData), .oIdle(oIdle)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    function automatic int target_of(input logic multi, input logic [7:0] blk);
        return (multi && blk != 8'd0) ? int'(blk) : 1;
    endfunction

    // Runs one request with an emulated PHY; abort_blk >= 0 raises iTimeout in that block's TRANSMIT.
    task automatic do_transfer(input logic wr, input logic [7:0] blk, input logic multi,
                               input logic ten, input logic [15:0] treg,
                               input int abort_blk, input int stall);
        int   cyc, tmr, fifo_wait, ok_cyc, send_cyc, d;
        logic prev_send, prev_ack, prev_cmp, done;
        obs_sends = 0; obs_acks = 0; obs_pulse = 0; obs_overlap = 0; obs_lat = -1;
        obs_idle_after = 1'b0;
        @(negedge iClock);
        iWriteRead = wr; iBlocks = blk; iMultipleData = multi;
        iTimeout_enable = ten; iTimeout_reg = treg; iNewData = 1'b1;
        iSerial_ready = 1'b0; iFIFO_ok = 1'b0; iComplete = 1'b0; iAck = 1'b0; iTimeout = 1'b0;
        @(negedge iClock);
        iNewData = 1'b0;
        iWriteRead = ~wr; iBlocks = blk + 8'd7; iMultipleData = ~multi;
        iTimeout_enable = ~ten; iTimeout_reg = ~treg;
        d = $urandom_range(0, 2);
        repeat (d) @(negedge iClock);
        iSerial_ready = 1'b1;
        fifo_wait = stall; ok_cyc = -1; send_cyc = -1; tmr = 0;
        prev_send = 1'b0; prev_ack = 1'b0; prev_cmp = 1'b0; done = 1'b0; cyc = 0;
        while (!done && cyc < 5000) begin
            if (fifo_wait > 0) begin
                iFIFO_ok = 1'b0;
                fifo_wait--;
            end else begin
                iFIFO_ok = (stall > 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                if (ok_cyc < 0 && iFIFO_ok) ok_cyc = cyc;
            end
            @(negedge iClock);
            cyc++;
            if (oSend && oAck) obs_overlap++;
            if (oSend && !prev_send) begin
                obs_sends++;
                tmr = $urandom_range(0, 3);
                if (send_cyc < 0) send_cyc = cyc;
            end
            if (oAck && !prev_ack) obs_acks++;
            if (oData_transfer_complete) obs_pulse++;
            if (prev_cmp && !oData_transfer_complete) begin
                done = 1'b1;
                obs_idle_after = oIdle;
            end
            iComplete = 1'b0;
            iTimeout  = 1'b0;
            if (oSend) begin
                if (tmr == 0) begin
                    if (obs_sends - 1 == abort_blk) iTimeout = 1'b1;
                    else iComplete = 1'b1;
                end else begin
                    tmr--;
                end
            end
            iAck = oAck ? 1'($urandom_range(0, 1)) : 1'b0;
            prev_send = oSend; prev_ack = oAck; prev_cmp = oData_transfer_complete;
        end
        obs_hung = !done;
        if (ok_cyc >= 0 && send_cyc >= 0) obs_lat = send_cyc - ok_cyc;
        obs_blocks = oBlocks; obs_tval = oTimeout_val; obs_wr = oWriteRead; obs_multi = oMultipleData;
        iSerial_ready = 1'b0; iFIFO_ok = 1'b0; iComplete = 1'b0; iTimeout = 1'b0; iAck = 1'b0;
    endtask

    task automatic test_reset;
        iReset = 1'b0; iNewData = 1'b0; iWriteRead = 1'b0; iBlocks = '0; iMultipleData = 1'b0;
        iTimeout_enable = 1'b0; iTimeout_reg = '0; iSerial_ready = 1'b0; iTimeout = 1'b0;
        iComplete = 1'b0; iAck = 1'b0; iFIFO_ok = 1'b0;
        repeat (2) @(negedge iClock);
        total++; if (oIdle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b exp=1", oIdle); end
        total++; if (oSend !== 1'b0) begin bad++; $display("FAIL reset_send got=%b exp=0", oSend); end
        total++; if (oAck !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", oAck); end
        total++; if (oBlocks !== 8'd0) begin bad++; $display("FAIL reset_blocks got=%0d exp=0", oBlocks); end
        total++; if (oTimeout_val !== 16'd0) begin bad++; $display("FAIL reset_tval got=%h exp=0", oTimeout_val); end
        total++; if (oData_transfer_complete !== 1'b0) begin bad++; $display("FAIL reset_cmp got=%b exp=0", oData_transfer_complete); end
        @(negedge iClock);
        iReset = 1'b1;
    endtask

    task automatic test_single_block;
        do_transfer(1'b1, 8'd5, 1'b0, 1'b0, 16'h0, -1, 0);
        total++; if (obs_hung !== 1'b0) begin bad++; $display("FAIL single_hung got=%b exp=0", obs_hung); end
        total++; if (obs_sends != 1) begin bad++; $display("FAIL single_sends got=%0d exp=1", obs_sends); end
        total++; if (obs_acks != 1) begin bad++; $display("FAIL single_acks got=%0d exp=1", obs_acks); end
        total++; if (obs_pulse != 1) begin bad++; $display("FAIL single_pulse got=%0d exp=1", obs_pulse); end
        total++; if (obs_idle_after !== 1'b1) begin bad++; $display("FAIL single_idle got=%b exp=1", obs_idle_after); end
        total++; if (obs_blocks !== 8'd5 || obs_wr !== 1'b1 || obs_multi !== 1'b0) begin
            bad++; $display("FAIL single_cfg got=%0d/%b/%b exp=5/1/0", obs_blocks, obs_wr, obs_multi); end
    endtask

    task automatic test_multi_block;
        do_transfer(1'b0, 8'd3, 1'b1, 1'b0, 16'h0, -1, 0);
        total++; if (obs_hung !== 1'b0) begin bad++; $display("FAIL multi_hung got=%b exp=0", obs_hung); end
        total++; if (obs_sends != 3) begin bad++; $display("FAIL multi_sends got=%0d exp=3", obs_sends); end
        total++; if (obs_acks != 3) begin bad++; $display("FAIL multi_acks got=%0d exp=3", obs_acks); end
        total++; if (obs_pulse != 1) begin bad++; $display("FAIL multi_pulse got=%0d exp=1", obs_pulse); end
        total++; if (obs_overlap != 0) begin bad++; $display("FAIL multi_overlap got=%0d exp=0", obs_overlap); end
    endtask

    task automatic test_block_boundaries;
        do_transfer(1'b1, 8'd0, 1'b1, 1'b0, 16'h0, -1, 0);
        total++; if (obs_sends != 1 || obs_acks != 1) begin
            bad++; $display("FAIL zero_blocks got=%0d/%0d exp=1/1", obs_sends, obs_acks); end
        do_transfer(1'b1, 8'd255, 1'b1, 1'b0, 16'h0, -1, 0);
        total++; if (obs_hung !== 1'b0 || obs_sends != 255 || obs_acks != 255 || obs_pulse != 1) begin
            bad++; $display("FAIL max_blocks got=%0d/%0d/%0d exp=255/255/1", obs_sends, obs_acks, obs_pulse); end
    endtask

    task automatic test_fifo_stall;
        do_transfer(1'b1, 8'd2, 1'b0, 1'b0, 16'h0, -1, 11);
        total++; if (obs_lat != 1) begin bad++; $display("FAIL stall_latency got=%0d exp=1", obs_lat); end
        total++; if (obs_sends != 1 || obs_pulse != 1) begin
            bad++; $display("FAIL stall_sends got=%0d/%0d exp=1/1", obs_sends, obs_pulse); end
    endtask

    task automatic test_timeout;
        do_transfer(1'b1, 8'd1, 1'b0, 1'b1, 16'h1234, 0, 0);
        total++; if (obs_tval !== 16'h1234) begin bad++; $display("FAIL tout_val got=%h exp=1234", obs_tval); end
        total++; if (obs_sends != 1 || obs_acks != 0 || obs_pulse != 1) begin
            bad++; $display("FAIL tout_abort got=%0d/%0d/%0d exp=1/0/1", obs_sends, obs_acks, obs_pulse); end
        do_transfer(1'b1, 8'd1, 1'b0, 1'b0, 16'h1234, -1, 0);
        total++; if (obs_tval !== 16'h0) begin bad++; $display("FAIL tout_disabled got=%h exp=0", obs_tval); end
        do_transfer(1'b0, 8'd4, 1'b1, 1'b1, 16'hBEEF, 2, 0);
        total++; if (obs_sends != 3 || obs_acks != 2 || obs_pulse != 1 || obs_idle_after !== 1'b1) begin
            bad++; $display("FAIL tout_mid got=%0d/%0d/%0d exp=3/2/1", obs_sends, obs_acks, obs_pulse); end
    endtask

    task automatic test_random;
        for (int n = 0; n < 25; n++) begin
            logic [7:0]  blk;
            logic        wr, multi, ten;
            logic [15:0] treg;
            int          tgt, abort, exp_s, exp_a;
            blk = 8'($urandom_range(0, 6)); wr = 1'($urandom); multi = 1'($urandom);
            ten = 1'($urandom); treg = 16'($urandom);
            tgt = target_of(multi, blk);
            abort = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, tgt - 1)) : -1;
            exp_s = (abort >= 0) ? abort + 1 : tgt;
            exp_a = (abort >= 0) ? abort : tgt;
            do_transfer(wr, blk, multi, ten, treg, abort, 0);
            total++; if (obs_hung !== 1'b0 || obs_sends != exp_s || obs_acks != exp_a || obs_pulse != 1
                         || obs_overlap != 0 || obs_idle_after !== 1'b1) begin
                bad++; $display("FAIL rand_flow[%0d] got=%0d/%0d/%0d/%0d exp=%0d/%0d/1/0", n,
                                obs_sends, obs_acks, obs_pulse, obs_overlap, exp_s, exp_a); end
            total++; if (obs_blocks !== blk || obs_wr !== wr || obs_multi !== multi
                         || obs_tval !== (ten ? treg : 16'h0)) begin
                bad++; $display("FAIL rand_cfg[%0d] got=%0d/%b/%b/%h exp=%0d/%b/%b/%h", n, obs_blocks,
                                obs_wr, obs_multi, obs_tval, blk, wr, multi, ten ? treg : 16'h0); end
        end
    endtask

    task automatic test_async_reset;
        @(negedge iClock);
        iWriteRead = 1'b1; iBlocks = 8'd2; iMultipleData = 1'b1; iTimeout_enable = 1'b1;
        iTimeout_reg = 16'h55AA; iNewData = 1'b1;
        @(negedge iClock);
        iNewData = 1'b0; iSerial_ready = 1'b1; iFIFO_ok = 1'b1;
        for (int c = 0; c < 50 && !oAck; c++) begin
            iComplete = oSend;
            @(negedge iClock);
        end
        iComplete = 1'b0;
        total++; if (oAck !== 1'b1) begin bad++; $display("FAIL arst_reach_ack got=%b exp=1", oAck); end
        #2 iReset = 1'b0;
        #1;
        total++; if (oAck !== 1'b0 || oSend !== 1'b0 || oData_transfer_complete !== 1'b0) begin
            bad++; $display("FAIL arst_handshake got=%b/%b/%b exp=0/0/0", oAck, oSend, oData_transfer_complete); end
        total++; if (oIdle !== 1'b1 || oBlocks !== 8'd0 || oTimeout_val !== 16'd0) begin
            bad++; $display("FAIL arst_regs got=%b/%0d/%h exp=1/0/0", oIdle, oBlocks, oTimeout_val); end
        iSerial_ready = 1'b0; iFIFO_ok = 1'b0;
        @(negedge iClock);
        iReset = 1'b1;
        do_transfer(1'b0, 8'd1, 1'b0, 1'b0, 16'h0, -1, 0);
        total++; if (obs_hung !== 1'b0 || obs_sends != 1 || obs_acks != 1) begin
            bad++; $display("FAIL arst_recover got=%0d/%0d exp=1/1", obs_sends, obs_acks); end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_multi_block();
        test_block_boundaries();
        test_fifo_stall();
        test_timeout();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
